tx_fcs_append: RTL

//  Nibble-stream Ethernet TX framer stage: passes frame nibbles through, zero-pads short frames
//  to minimum length, then appends the 32-bit FCS as 8 nibbles. Sits between TX MAC data path
//  and MII output; wraps one crc_comb instance as its CRC-32 next-state function.

---
 rtl/crc_pkg.sv | 27 ++
 rtl/crc_comb.sv | 30 +++
 rtl/tx_fcs_append.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared CRC-32 constants and the framer state type.
//   CRC_INIT     - register value at start of every frame
//   CRC_RESIDUE  - register value after a whole frame plus its FCS has been stepped through
//   CRC_POLY     - IEEE 802.3 generator polynomial, MSB-first form
//   FCS_NIBBLES  - number of FCS nibbles appended to each frame
//   fcs_state_e  - framer states (IDLE/DATA/PAD/FCS)
package crc_pkg;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam int          FCS_NIBBLES = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAD  = 2'd2,
    FCS  = 2'd3
  } fcs_state_e;

  // MII sends bit 0 of each nibble first; the MSB-first CRC core wants the
  // first wire bit in position 3.
  function automatic logic [3:0] nibble_rev(input logic [3:0] d);
    return {d[0], d[1], d[2], d[3]};
  endfunction

endpackage

// File: rtl/crc_comb.sv
// Combinational CRC-32 next-state function, one nibble per step.
// Ports:
//   data      in  4   nibble, bit 3 is processed first
//   enable    in  1   0 = pass curr_crc through unchanged
//   curr_crc  in  32  current CRC register
//   next_crc  out 32  CRC register after stepping data
module crc_comb
  import crc_pkg::*;
(
  input  logic [3:0]  data,
  input  logic        enable,
  input  logic [31:0] curr_crc,
  output logic [31:0] next_crc
);

  logic [31:0] crc_work;

  always_comb begin
    crc_work = curr_crc;
    for (int i = 3; i >= 0; i--) begin
      if (crc_work[31] ^ data[i]) begin
        crc_work = {crc_work[30:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_work = {crc_work[30:0], 1'b0};
      end
    end
    next_crc = enable ? crc_work : curr_crc;
  end

endmodule

// File: rtl/tx_fcs_append.sv
// Nibble-stream Ethernet TX framer: passes frame nibbles through, zero-pads
// short frames to MIN_NIBBLES, then appends the 32-bit FCS as 8 nibbles.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready/in_data     input nibble handshake (MII nibble order)
//   in_first/in_last              frame delimiters on the input side
//   out_valid/out_ready/out_data  output nibble handshake (registered)
//   out_first/out_last            first nibble / last FCS nibble of output frame
//   busy                          high while a frame is in progress
//
// state | meaning
// IDLE  | waiting for in_first; non-first nibbles are dropped
// DATA  | forwarding frame nibbles and stepping the CRC
// PAD   | emitting zero nibbles until MIN_NIBBLES reached
// FCS   | emitting the inverted CRC, 4 bits per nibble
module tx_fcs_append
  import crc_pkg::*;
#(
  parameter bit PAD_EN      = 1'b1,
  parameter int MIN_NIBBLES = 120,
  parameter int CNT_W       = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic       in_first,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       out_first,
  output logic       out_last,
  output logic       busy
);

  localparam logic [2:0]     FCS_LAST = 3'(FCS_NIBBLES - 1);
  localparam logic [CNT_W:0] MIN_CNT  = (CNT_W + 1)'(MIN_NIBBLES);

  fcs_state_e       state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       fcs_idx_q, fcs_idx_d;
  logic             out_valid_d, out_first_d, out_last_d;
  logic [3:0]       out_data_d;

  logic             advance, xfer, pad_needed;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_sat;
  logic [3:0]       step_data;
  logic [31:0]      step_base, step_crc;

  assign advance  = !out_valid || out_ready;
  // Gated with rst_n so nothing is handshaken while the block is held in reset.
  assign in_ready = rst_n && advance && (state_q == IDLE || state_q == DATA);
  assign xfer     = in_valid && in_ready;
  assign busy     = (state_q != IDLE);

  // Extra bit keeps cnt+1 from wrapping, so a saturated count never looks short.
  assign cnt_inc    = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign cnt_sat    = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];
  // cnt is 0 in IDLE, so the same test covers a single-nibble frame.
  assign pad_needed = PAD_EN && (cnt_inc < MIN_CNT);

  // The first nibble of a frame steps from INIT rather than the stale register.
  assign step_base = (state_q == IDLE) ? CRC_INIT : crc_q;
  assign step_data = (state_q == PAD) ? 4'h0 : nibble_rev(in_data);

  crc_comb u_crc_comb (
    .data     (step_data),
    .enable   (1'b1),
    .curr_crc (step_base),
    .next_crc (step_crc)
  );

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    fcs_idx_d   = fcs_idx_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_first_d = out_first;
    out_last_d  = out_last;

    if (advance) begin
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer && in_first) begin
            crc_d       = step_crc;
            cnt_d       = CNT_W'(1);
            fcs_idx_d   = '0;
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_first_d = 1'b1;
            if (in_last) state_d = pad_needed ? PAD : FCS;
            else         state_d = DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            crc_d       = step_crc;
            cnt_d       = cnt_sat;
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            if (in_last) begin
              state_d   = pad_needed ? PAD : FCS;
              fcs_idx_d = '0;
            end
          end
        end
        PAD: begin
          crc_d       = step_crc;
          cnt_d       = cnt_sat;
          out_valid_d = 1'b1;
          out_data_d  = 4'h0;
          if (cnt_inc >= MIN_CNT) begin
            state_d   = FCS;
            fcs_idx_d = '0;
          end
        end
        FCS: begin
          out_valid_d = 1'b1;
          out_data_d  = {~crc_q[28], ~crc_q[29], ~crc_q[30], ~crc_q[31]};
          crc_d       = {crc_q[27:0], 4'h0};
          fcs_idx_d   = fcs_idx_q + 3'd1;
          if (fcs_idx_q == FCS_LAST) begin
            out_last_d = 1'b1;
            state_d    = IDLE;
            crc_d      = CRC_INIT;
            cnt_d      = '0;
            fcs_idx_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      crc_q     <= CRC_INIT;
      cnt_q     <= '0;
      fcs_idx_q <= '0;
      out_valid <= 1'b0;
      out_data  <= 4'h0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      fcs_idx_q <= fcs_idx_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_first <= out_first_d;
      out_last  <= out_last_d;
    end
  end

endmodule
